// File: rtl/byte_tx_port.sv
// Bus-writable byte FIFO draining to a valid/ready byte stream.
// Optional irq on empty is enabled by defining BYTE_TX_PORT_IRQ_EN.
module byte_tx_port #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] address,
  input  logic [3:0]  wstrobe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
`ifdef BYTE_TX_PORT_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [2:0]    n_push;
  logic [AW-1:0] off [4];
  logic          is_status;
  logic          data_wr;
  logic          space_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic          flush;
  logic          empty;
  logic          full;
  logic          irq_bit;
  logic [31:0]   rd_val;
  logic          unused_addr;

  assign unused_addr = ^{address[31:3], address[1:0]};

  assign is_status = address[2];
  assign data_wr   = !is_status && (wstrobe != 4'd0);
  assign n_push    = 3'(wstrobe[0]) + 3'(wstrobe[1])
                   + 3'(wstrobe[2]) + 3'(wstrobe[3]);
  assign free      = CW'(DEPTH) - count;
  // Space is judged on the registered count only.
  assign space_ok  = !data_wr || (free >= CW'(n_push));
  assign accept    = valid && !ready && space_ok;
  assign push      = accept && data_wr;
  assign flush     = accept && is_status
                   && wstrobe[0] && wdata[0];

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;

`ifdef BYTE_TX_PORT_IRQ_EN
  logic irq_enable;
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif

  always_comb begin
    off[0] = '0;
    for (int i = 1; i < 4; i++)
      off[i] = off[i-1] + AW'(wstrobe[i-1]);
  end

  always_comb begin
    rd_val = 32'd0;
    if (is_status)
      rd_val = {20'd0, irq_bit, full, empty, 9'(count)};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 4; i++)
        if (wstrobe[i])
          mem[wr_ptr + off[i]] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready  <= 1'b0;
      rdata  <= 32'd0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      ready <= accept;
      rdata <= accept ? rd_val : 32'd0;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(n_push);
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count
               + CW'(push ? n_push : 3'd0)
               - CW'(pop);
      end
    end
  end

`ifdef BYTE_TX_PORT_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_enable <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (accept && is_status && wstrobe[0])
        irq_enable <= wdata[1];
      irq <= irq_enable && empty;
    end
  end
`endif

endmodule

// File: tb/tb_byte_tx_port.sv
// Scoreboard bench for byte_tx_port: bus responses and tx bytes
// are queued by the stimulus and checked by independent monitors.
module tb_byte_tx_port;

  logic        clk;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
`ifdef BYTE_TX_PORT_IRQ_EN
  logic        irq;
`endif

  typedef struct packed {
    logic        chk;
    logic [31:0] val;
  } exp_t;

  exp_t       sbq [$];
  logic [7:0] txq [$];
  int tests = 0;
  int fails = 0;

  byte_tx_port #(.DEPTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .ready    (ready),
    .address  (address),
    .wstrobe  (wstrobe),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
`ifdef BYTE_TX_PORT_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus response monitor and tx byte monitor.
  always @(negedge clk) begin
    exp_t e;
    if (ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bus_spurious: got ready=1 expected none");
      end else begin
        e = sbq.pop_front();
        if (e.chk)
          check("bus_rdata", rdata, e.val);
      end
    end else begin
      check("rdata_idle", rdata, 32'd0);
    end
    if (tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_spurious: got %h expected none", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
      end
    end
  end

  task automatic expect_tx(input logic [3:0] s,
                           input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      if (s[i]) txq.push_back(d[8*i +: 8]);
  endtask

  task automatic bus(input logic st, input logic [3:0] s,
                     input logic [31:0] d, input logic chk,
                     input logic [31:0] exp);
    int n;
    sbq.push_back('{chk, exp});
    if (!st) expect_tx(s, d);
    address = st ? 32'h4 : 32'h0;
    wstrobe = s;
    wdata   = d;
    valid   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 100);
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL bus_timeout: got no ready expected ready");
    end
    valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid    = 1'b0;
    address  = 32'd0;
    wstrobe  = 4'd0;
    wdata    = 32'd0;
    tx_ready = 1'b0;
    cycles(3);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_txv", 32'(tx_valid), 32'd0);
    reset = 1'b0;
    cycles(1);

    bus(1, 4'b0000, 32'd0, 1, 32'h200);
    check("idle_txv", 32'(tx_valid), 32'd0);
    bus(0, 4'b0000, 32'hDEADBEEF, 1, 32'd0);

    // Sparse lane write then drain.
    bus(0, 4'b1011, 32'h44332211, 0, 32'd0);
    bus(1, 4'b0000, 32'd0, 1, 32'h003);
    tx_ready = 1'b1;
    cycles(4);
    tx_ready = 1'b0;
    check("drain_txv", 32'(tx_valid), 32'd0);
    check("drain_q", 32'(txq.size()), 32'd0);
    bus(1, 4'b0000, 32'd0, 1, 32'h200);

    // Back-pressure: 14 queued, a 3-byte write must wait.
    bus(0, 4'b1111, 32'h03020100, 0, 32'd0);
    bus(0, 4'b1111, 32'h07060504, 0, 32'd0);
    bus(0, 4'b1111, 32'h0B0A0908, 0, 32'd0);
    bus(0, 4'b0011, 32'h00000D0C, 0, 32'd0);
    bus(1, 4'b0000, 32'd0, 1, 32'h00E);
    sbq.push_back('{1'b0, 32'd0});
    expect_tx(4'b0111, 32'h00121110);
    address = 32'h0;
    wstrobe = 4'b0111;
    wdata   = 32'h00121110;
    valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check("stall_ready", 32'(ready), 32'd0);
    end
    tx_ready = 1'b1;
    cycles(1);
    tx_ready = 1'b0;
    check("no_credit", 32'(ready), 32'd0);
    cycles(1);
    check("accept_after_pop", 32'(ready), 32'd1);
    valid = 1'b0;
    bus(1, 4'b0000, 32'd0, 1, 32'h410);
    tx_ready = 1'b1;
    cycles(20);
    tx_ready = 1'b0;
    check("wrap_drain_txv", 32'(tx_valid), 32'd0);
    check("wrap_drain_q", 32'(txq.size()), 32'd0);
    bus(1, 4'b0000, 32'd0, 1, 32'h200);

    // No-op status write, then flush racing a pop.
    bus(0, 4'b1111, 32'h54535251, 0, 32'd0);
    bus(0, 4'b0001, 32'h00000055, 0, 32'd0);
    bus(1, 4'b0001, 32'h00000000, 0, 32'd0);
    bus(1, 4'b0000, 32'd0, 1, 32'h005);
    tx_ready = 1'b1;
    bus(1, 4'b0001, 32'h00000001, 0, 32'd0);
    txq.delete();
    check("flush_txv", 32'(tx_valid), 32'd0);
    cycles(1);
    check("flush_txv_next", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    bus(1, 4'b0000, 32'd0, 1, 32'h200);

    // Reset while a write is stalled on a full FIFO.
    for (int i = 0; i < 4; i++)
      bus(0, 4'b1111, 32'hA0A1A2A3 + 32'(i), 0, 32'd0);
    bus(1, 4'b0000, 32'd0, 1, 32'h410);
    sbq.push_back('{1'b0, 32'd0});
    address = 32'h0;
    wstrobe = 4'b0001;
    wdata   = 32'h000000AA;
    valid   = 1'b1;
    cycles(2);
    check("full_stall", 32'(ready), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycles(1);
      check("rst_no_ack", 32'(ready), 32'd0);
      check("rst_txv_mid", 32'(tx_valid), 32'd0);
    end
    txq.delete();
    txq.push_back(8'hAA);
    reset = 1'b0;
    cycles(1);
    check("reissue_ack", 32'(ready), 32'd1);
    valid = 1'b0;
    bus(1, 4'b0000, 32'd0, 1, 32'h001);
    tx_ready = 1'b1;
    cycles(3);
    tx_ready = 1'b0;
    check("reissue_drain", 32'(txq.size()), 32'd0);
    bus(1, 4'b0000, 32'd0, 1, 32'h200);

`ifdef BYTE_TX_PORT_IRQ_EN
    bus(1, 4'b0001, 32'h00000002, 0, 32'd0);
    bus(1, 4'b0000, 32'd0, 1, 32'hA00);
    bus(0, 4'b0001, 32'h00000077, 0, 32'd0);
    check("irq_hold", 32'(irq), 32'd1);
    cycles(1);
    check("irq_fall", 32'(irq), 32'd0);
    tx_ready = 1'b1;
    cycles(1);
    tx_ready = 1'b0;
    check("irq_lag", 32'(irq), 32'd0);
    cycles(1);
    check("irq_rise", 32'(irq), 32'd1);
    bus(1, 4'b0001, 32'h00000000, 0, 32'd0);
    check("irq_dis_lag", 32'(irq), 32'd1);
    cycles(1);
    check("irq_dis", 32'(irq), 32'd0);
`endif

    cycles(2);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
